// File: rtl/flash_rom_loader_pkg.sv
// Shared constants for the Hack boot loader: SPI flash opcodes and loader FSM states.
package flash_rom_loader_pkg;

   localparam logic [7:0] FLASH_CMD_WAKE = 8'hAB;
   localparam logic [7:0] FLASH_CMD_READ = 8'h03;

   typedef enum logic [2:0] {
      WAKE_CMD  = 3'd0,
      WAKE_WAIT = 3'd1,
      READ_CMD  = 3'd2,
      READ_DATA = 3'd3,
      DONE      = 3'd4
   } state_t;

endpackage

// File: rtl/flash_rom_loader_spi_shifter.sv
// Mode-0 SPI bit engine: 2 clk cycles per bit, up to 32 bits out MSB first, 16-bit receive window.
module spi_shifter
   import flash_rom_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [5:0]  i_nbits,
   input  logic [31:0] i_tx,
   input  logic        i_miso,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_rx,
   output logic        o_sclk,
   output logic        o_mosi
);

   logic        r_busy;
   logic        r_phase;
   logic [5:0]  r_cnt;
   logic [31:0] r_sh;
   logic [14:0] r_rx;

   // o_done marks the last high phase; a start in that cycle chains the next transfer with no gap.
   assign o_done = r_busy & r_phase & (r_cnt == 6'd1);
   assign o_rx   = {r_rx, i_miso};
   assign o_busy = r_busy;
   assign o_sclk = r_busy & r_phase;
   assign o_mosi = r_busy & r_sh[31];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_busy  <= 1'b0;
         r_phase <= 1'b0;
         r_cnt   <= '0;
         r_sh    <= '0;
         r_rx    <= '0;
      end else begin
         if (r_busy && r_phase) begin
            r_rx    <= o_rx[14:0];
            r_sh    <= {r_sh[30:0], 1'b0};
            r_cnt   <= r_cnt - 6'd1;
            r_phase <= 1'b0;
            if (r_cnt == 6'd1)
               r_busy <= 1'b0;
         end else if (r_busy) begin
            r_phase <= 1'b1;
         end
         if (i_start && (!r_busy || o_done)) begin
            r_busy  <= 1'b1;
            r_phase <= 1'b0;
            r_cnt   <= i_nbits;
            r_sh    <= i_tx;
         end
      end
   end

endmodule

// File: rtl/flash_rom_loader.sv
// Boot loader: wakes SPI flash, copies the program image into instruction RAM, then serves CPU fetches.
module flash_rom_loader
   import flash_rom_loader_pkg::*;
#(
   parameter int unsigned WORDS        = 8192,
   parameter logic [23:0] FLASH_OFFSET = 24'h100000,
   parameter int unsigned WAKE_CYCLES  = 48
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ready,
   input  logic [15:0] address,
   output logic [15:0] instruction,
   output logic        spi_cs,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam int unsigned AW        = $clog2(WORDS);
   localparam logic [AW:0] LAST_WORD = (AW + 1)'(WORDS - 1);
   localparam logic [15:0] LAST_WAIT = 16'(WAKE_CYCLES - 1);

   state_t        r_state;
   logic          r_cs;
   logic          r_ready;
   logic [AW:0]   r_wc;
   logic [15:0]   r_wait;
   logic [15:0]   r_instr;
   logic [15:0]   r_ram [0:WORDS-1];

   logic          w_start;
   logic [5:0]    w_nbits;
   logic [31:0]   w_tx;
   logic          w_busy;
   logic          w_done;
   logic [15:0]   w_rx;
   logic          w_last_word;
   logic [AW-1:0] w_addr;

   assign w_addr      = address[AW-1:0];
   assign w_last_word = (r_wc == LAST_WORD);

   generate
      if (AW < 16) begin : g_addr_hi
         logic w_addr_unused;
         assign w_addr_unused = ^address[15:AW];
      end
   endgenerate

   spi_shifter u_shifter (
      .i_clk   (clk),
      .i_reset (reset),
      .i_start (w_start),
      .i_nbits (w_nbits),
      .i_tx    (w_tx),
      .i_miso  (spi_miso),
      .o_busy  (w_busy),
      .o_done  (w_done),
      .o_rx    (w_rx),
      .o_sclk  (spi_sclk),
      .o_mosi  (spi_mosi)
   );

   // Command and data words are chained on w_done so READ_CMD/READ_DATA stream without idle cycles.
   always_comb begin
      w_start = 1'b0;
      w_nbits = 6'd16;
      w_tx    = '0;
      case (r_state)
         WAKE_CMD: begin
            w_start = !r_cs && !w_busy;
            w_nbits = 6'd8;
            w_tx    = {FLASH_CMD_WAKE, 24'h000000};
         end
         READ_CMD: begin
            if (!w_busy) begin
               w_start = 1'b1;
               w_nbits = 6'd32;
               w_tx    = {FLASH_CMD_READ, FLASH_OFFSET};
            end else begin
               w_start = w_done;
            end
         end
         READ_DATA: w_start = w_done && !w_last_word;
         default:   w_start = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= WAKE_CMD;
         r_cs    <= 1'b1;
         r_ready <= 1'b0;
         r_wc    <= '0;
         r_wait  <= '0;
      end else begin
         case (r_state)
            WAKE_CMD: begin
               if (r_cs) begin
                  r_cs <= 1'b0;
               end else if (w_done) begin
                  r_cs    <= 1'b1;
                  r_wait  <= '0;
                  r_state <= WAKE_WAIT;
               end
            end
            WAKE_WAIT: begin
               if (r_wait == LAST_WAIT) begin
                  r_cs    <= 1'b0;
                  r_state <= READ_CMD;
               end else begin
                  r_wait <= r_wait + 16'd1;
               end
            end
            READ_CMD: begin
               if (w_done)
                  r_state <= READ_DATA;
            end
            READ_DATA: begin
               if (w_done) begin
                  r_wc <= r_wc + (AW + 1)'(1);
                  if (w_last_word) begin
                     r_cs    <= 1'b1;
                     r_ready <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            DONE:    r_state <= DONE;
            default: r_state <= WAKE_CMD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == READ_DATA && w_done)
         r_ram[r_wc[AW-1:0]] <= w_rx;
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_instr <= '0;
      else
         r_instr <= r_ready ? r_ram[w_addr] : 16'h0000;
   end

   assign ready       = r_ready;
   assign instruction = r_instr;
   assign spi_cs      = r_cs;

endmodule
